// File: rtl/sha256_w_pipe_sched.sv
// ---------------------------------------------------------------------------
// sha256_w_pipe_sched
//
// Issue scheduler for the unrolled message-expander pipeline of the
// double-SHA256 miner. It sweeps an inclusive nonce range and issues one
// candidate per advancing cycle into stage 0. It also drives the shared stage
// write enable, which is the global advance/stall for the pipeline. A valid
// bit travels alongside each candidate in a shift register, and a second
// nonce counter follows the issue counter. Because the pipeline preserves
// order, that counter tags every candidate leaving the last stage with its
// nonce.
//
// Ports
//   CLK          clock, all state on the rising edge
//   RST          asynchronous active-low reset
//   start        begin a job (sampled only in IDLE)
//   nonce_start  first nonce, captured on an accepted start
//   nonce_end    last nonce (inclusive), captured on an accepted start
//   abort        cancel the running job; highest priority
//   stall        downstream not ready; freezes the whole pipeline
//   pipe_en      write enable to every expander stage register
//   issue_valid  candidate entering stage 0 this cycle
//   issue_nonce  nonce of the issued candidate
//   out_valid    valid candidate leaving the last stage this cycle
//   out_nonce    nonce of that candidate
//   inflight     number of valid candidates inside the pipeline
//   busy         scheduler is not IDLE
//   done         one-cycle pulse once the job has fully drained
// ---------------------------------------------------------------------------
module sha256_w_pipe_sched #(
  parameter int STAGES = 48,
  parameter int CNT_W  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [31:0]      nonce_start,
  input  logic [31:0]      nonce_end,
  input  logic             abort,
  input  logic             stall,
  output logic             pipe_en,
  output logic             issue_valid,
  output logic [31:0]      issue_nonce,
  output logic             out_valid,
  output logic [31:0]      out_nonce,
  output logic [CNT_W-1:0] inflight,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [STAGES-1:0] valid_sr;
  logic [31:0]       issue_ctr;
  logic [31:0]       out_ctr;
  logic [31:0]       end_nonce;
  logic [CNT_W-1:0]  inflight_q;

  logic accept;
  logic active;
  logic advance;
  logic do_issue;
  logic do_out;
  logic last_issue;
  logic last_out;
  logic kill;

  // The pipeline moves only in RUN/DRAIN. Abort also freezes the stage
  // registers, because their contents stop mattering once the job is dropped.
  assign accept     = (state == ST_IDLE) && start && !abort;
  assign active     = (state == ST_RUN) || (state == ST_DRAIN);
  assign kill       = active && abort;
  assign advance    = active && !stall && !abort;
  assign do_issue   = advance && (state == ST_RUN);
  assign do_out     = advance && valid_sr[STAGES-1];
  // Stop issuing when the range end itself has been issued. This is an
  // equality test, so wrapping ranges (end < start) and the full 2^32 sweep
  // (end == start-1) need no special handling.
  assign last_issue = do_issue && (issue_ctr == end_nonce);
  // In DRAIN nothing is issued, so the last out_valid is the one seen
  // while exactly one candidate remains.
  assign last_out   = (state == ST_DRAIN) && do_out && (inflight_q == CNT_ONE);

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)           state_nxt = ST_IDLE;
        else if (last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (last_out) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Nonce counters. out_ctr starts at the same nonce as issue_ctr and
  // advances once per exit. Order is preserved, so it always holds the
  // nonce of the candidate at the pipeline output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_ctr <= '0;
      out_ctr   <= '0;
      end_nonce <= '0;
    end else if (accept) begin
      issue_ctr <= nonce_start;
      out_ctr   <= nonce_start;
      end_nonce <= nonce_end;
    end else begin
      if (do_issue) issue_ctr <= issue_ctr + 32'd1;
      if (do_out)   out_ctr   <= out_ctr + 32'd1;
    end
  end

  // NOTE: the valid shift register is a real reset target, unlike the stage
  // data it shadows. A stale valid bit after reset would emit a phantom
  // candidate.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_sr   <= '0;
      inflight_q <= '0;
    end else if (kill || accept) begin
      valid_sr   <= '0;
      inflight_q <= '0;
    end else if (advance) begin
      valid_sr <= {valid_sr[STAGES-2:0], do_issue};
      if (do_issue && !do_out)      inflight_q <= inflight_q + CNT_ONE;
      else if (!do_issue && do_out) inflight_q <= inflight_q - CNT_ONE;
    end
  end

  assign pipe_en     = advance;
  assign issue_valid = do_issue;
  assign issue_nonce = issue_ctr;
  assign out_valid   = do_out;
  assign out_nonce   = out_ctr;
  assign inflight    = inflight_q;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_sha256_w_pipe_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_w_pipe_sched
//
// Bench for the expander pipeline scheduler. Each issued nonce is checked
// against the nonce the bench expects next. It is then pushed to a
// scoreboard together with the cycle number and the number of stall cycles
// seen so far. Each out_valid pops the scoreboard and checks the nonce and
// the advance-only latency. A table of jobs covers the normal, stalled,
// wrapping and single-nonce ranges. Hand-written sequences cover abort,
// abort+start in IDLE and asynchronous reset in mid-job.
// ---------------------------------------------------------------------------
module tb_sha256_w_pipe_sched;

  localparam int STAGES = 48;
  localparam int CNT_W  = 6;

  logic             CLK;
  logic             RST;
  logic             start;
  logic [31:0]      nonce_start;
  logic [31:0]      nonce_end;
  logic             abort;
  logic             stall;
  logic             pipe_en;
  logic             issue_valid;
  logic [31:0]      issue_nonce;
  logic             out_valid;
  logic [31:0]      out_nonce;
  logic [CNT_W-1:0] inflight;
  logic             busy;
  logic             done;

  sha256_w_pipe_sched #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .abort       (abort),
    .stall       (stall),
    .pipe_en     (pipe_en),
    .issue_valid (issue_valid),
    .issue_nonce (issue_nonce),
    .out_valid   (out_valid),
    .out_nonce   (out_nonce),
    .inflight    (inflight),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] ns;
    logic [31:0] ne;
    int          n;            // nonces expected to be issued and output
    int          stall_after;  // issue count after which the stall begins
    int          stall_len;    // stall cycles (0: none)
    int          late_start;   // pulse a second start during DRAIN
    int          exp_peak;     // expected max inflight
    int          exp_busy;     // expected cycles with busy && !done
  } job_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard and monitor state
  logic [31:0] sb_nonce[$];
  int          sb_cyc[$];
  int          sb_stl[$];
  logic [31:0] exp_issue;
  int          cyc = 0;
  int          stall_cyc = 0;
  int          n_issued = 0;
  int          n_out = 0;
  int          n_done = 0;
  int          last_out_cyc = -10;
  int          busy_run = 0;
  int          peak = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle. Inputs are already driven; outputs are sampled 3 ns
  // after the rising edge, then the task waits for the next edge.
  task automatic cycle();
    logic [31:0] nn;
    int          ic;
    int          is;
    #2;
    check("inflight_vs_scoreboard", 32'(inflight), 32'(sb_nonce.size()));
    check("pipe_en", 32'(pipe_en), 32'(busy && !done && !stall && !abort));
    if (stall || abort) begin
      check("frozen_issue_valid", 32'(issue_valid), 32'd0);
      check("frozen_out_valid", 32'(out_valid), 32'd0);
    end
    if (issue_valid) begin
      check("issue_nonce", issue_nonce, exp_issue);
      sb_nonce.push_back(exp_issue);
      sb_cyc.push_back(cyc);
      sb_stl.push_back(stall_cyc);
      exp_issue = exp_issue + 32'd1;
      n_issued++;
    end
    if (out_valid) begin
      if (sb_nonce.size() == 0) begin
        check("out_valid_unexpected", 32'd1, 32'd0);
      end else begin
        nn = sb_nonce.pop_front();
        ic = sb_cyc.pop_front();
        is = sb_stl.pop_front();
        check("out_nonce", out_nonce, nn);
        check("latency_advances", 32'((cyc - ic) - (stall_cyc - is)), 32'(STAGES));
        n_out++;
        last_out_cyc = cyc;
      end
    end
    if (done) begin
      n_done++;
      check("done_after_last_out", 32'(cyc), 32'(last_out_cyc + 1));
    end
    if (busy && !done) busy_run++;
    if (32'(inflight) > 32'(peak)) peak = int'(inflight);
    if (stall) stall_cyc++;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_sb();
    sb_nonce.delete();
    sb_cyc.delete();
    sb_stl.delete();
  endtask

  task automatic run_job(input job_t j);
    int stall_rem;
    int t;
    stall_rem = j.stall_len;
    n_issued  = 0;
    n_out     = 0;
    n_done    = 0;
    busy_run  = 0;
    peak      = 0;
    exp_issue = j.ns;
    nonce_start = j.ns;
    nonce_end   = j.ne;
    start = 1'b1;
    cycle();
    start = 1'b0;
    t = 0;
    while (n_done == 0 && t < 600) begin
      stall = 1'b0;
      if (stall_rem > 0 && n_issued >= j.stall_after) begin
        stall = 1'b1;
        stall_rem--;
      end
      if (j.late_start != 0 && t == 20) begin
        nonce_start = 32'h99;
        nonce_end   = 32'h99;
        start       = 1'b1;
      end
      cycle();
      start = 1'b0;
      t++;
    end
    stall = 1'b0;
    check("job_done_seen", 32'(n_done), 32'd1);
    check("job_issued", 32'(n_issued), 32'(j.n));
    check("job_outputs", 32'(n_out), 32'(j.n));
    check("job_peak_inflight", 32'(peak), 32'(j.exp_peak));
    check("job_busy_cycles", 32'(busy_run), 32'(j.exp_busy));
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  job_t jobs[4];
  int   hold_out;
  int   hold_iss;
  int   t;

  initial begin
    jobs[0] = '{32'h0000_0010, 32'h0000_0013, 4, 0, 0, 0, 4, 4 + STAGES};
    jobs[1] = '{32'h0000_0000, 32'h0000_0009, 10, 3, 5, 0, 10, 10 + STAGES + 5};
    jobs[2] = '{32'hFFFF_FFFE, 32'h0000_0001, 4, 0, 0, 0, 4, 4 + STAGES};
    jobs[3] = '{32'h0000_0055, 32'h0000_0055, 1, 0, 0, 1, 1, 1 + STAGES};

    RST = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    nonce_start = '0;
    nonce_end   = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pipe_en", 32'(pipe_en), 32'd0);
    check("reset_inflight", 32'(inflight), 32'd0);
    check("reset_issue_nonce", issue_nonce, 32'd0);
    check("reset_out_nonce", out_nonce, 32'd0);
    #25;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Stall in IDLE does nothing.
    stall = 1'b1;
    cycle();
    cycle();
    stall = 1'b0;
    check("idle_stall_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_job(jobs[i]);
      repeat (2) cycle();
    end

    // Abort together with start in IDLE: abort wins.
    nonce_start = 32'h777;
    nonce_end   = 32'h778;
    start = 1'b1;
    abort = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle_busy", 32'(busy), 32'd0);
    hold_iss = n_issued;
    repeat (3) cycle();
    check("abort_start_idle_no_issue", 32'(n_issued), 32'(hold_iss));

    // Abort on the 20th issue cycle.
    n_issued = 0;
    n_out = 0;
    n_done = 0;
    exp_issue = 32'h100;
    nonce_start = 32'h100;
    nonce_end   = 32'h1FF;
    start = 1'b1;
    cycle();
    start = 1'b0;
    t = 0;
    while (n_issued < 19 && t < 100) begin
      cycle();
      t++;
    end
    check("abort_pre_issues", 32'(n_issued), 32'd19);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_inflight", 32'(inflight), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_issued", 32'(n_issued), 32'd19);
    clear_sb();
    hold_out = n_out;
    repeat (60) cycle();
    check("abort_no_out", 32'(n_out), 32'(hold_out));
    check("abort_no_done", 32'(n_done), 32'd0);
    run_job('{32'h200, 32'h202, 3, 0, 0, 0, 3, 3 + STAGES});
    repeat (2) cycle();

    // Asynchronous reset while the job is in RUN.
    exp_issue = 32'h300;
    nonce_start = 32'h300;
    nonce_end   = 32'h3FF;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    #3;
    RST = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_pipe_en", 32'(pipe_en), 32'd0);
    check("rst_async_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_async_issue_nonce", issue_nonce, 32'd0);
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_out_nonce", out_nonce, 32'd0);
    check("rst_async_inflight", 32'(inflight), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    clear_sb();
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    hold_iss = n_issued;
    hold_out = n_out;
    repeat (60) cycle();
    check("rst_after_no_issue", 32'(n_issued), 32'(hold_iss));
    check("rst_after_no_out", 32'(n_out), 32'(hold_out));
    check("rst_after_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
